// File: rtl/alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl
//
// Shares one combinational ALU between NREQ requesters. A round-robin arbiter
// grants one requester in IDLE, its operands are latched into an operand
// register that drives the ALU for exactly one cycle (EXEC), and the result
// plus flags are captured and presented on a single tagged response channel
// (RESP) until the consumer accepts them.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      per-requester handshake (ready is one-hot or 0)
//   req_op1, req_op2           flattened operands, requester k at [k*LENGTH +: LENGTH]
//   req_operation, req_mode    flattened 3-bit opcodes and per-requester mode bits
//   alu_op1/op2/operation/mode operands to the shared ALU (registered)
//   alu_out, alu_carry, alu_zero, alu_sign, alu_overflow   ALU result and flags
//   rsp_valid / rsp_ready      response handshake
//   rsp_id, rsp_out, rsp_flags owner index, result, {carry, zero, sign, overflow}
//   busy                       high whenever a transaction is in flight
// -----------------------------------------------------------------------------

// Protocol checker bound inside the controller; it observes ports only.
module alu_share_ctrl_chk #(
    parameter int NREQ   = 4,
    parameter int LENGTH = 32,
    parameter int IDW    = 2
) (
    input logic              clk,
    input logic              rst_n,
    input logic [NREQ-1:0]   req_ready,
    input logic              rsp_valid,
    input logic              rsp_ready,
    input logic [IDW-1:0]    rsp_id,
    input logic [LENGTH-1:0] rsp_out,
    input logic [3:0]        rsp_flags,
    input logic              busy
);

    // At most one requester may be accepted in any cycle.
    a_ready_onehot0: assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(req_ready)
    );

    // No acceptance while a transaction is in flight.
    a_no_ready_when_busy: assert property (
        @(posedge clk) disable iff (!rst_n) busy |-> (req_ready == {NREQ{1'b0}})
    );

    // A stalled response keeps all of its fields.
    a_rsp_stable: assert property (
        @(posedge clk) disable iff (!rst_n)
        (rsp_valid && !rsp_ready) |=>
            (rsp_valid && $stable(rsp_id) && $stable(rsp_out) && $stable(rsp_flags))
    );

    // A valid response always implies the controller reports busy.
    a_rsp_implies_busy: assert property (
        @(posedge clk) disable iff (!rst_n) rsp_valid |-> busy
    );

endmodule

module alu_share_ctrl #(
    parameter int NREQ   = 4,
    parameter int LENGTH = 32,
    parameter int IDW    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*LENGTH-1:0] req_op1,
    input  logic [NREQ*LENGTH-1:0] req_op2,
    input  logic [NREQ*3-1:0]    req_operation,
    input  logic [NREQ-1:0]      req_mode,
    output logic [LENGTH-1:0]    alu_op1,
    output logic [LENGTH-1:0]    alu_op2,
    output logic [2:0]           alu_operation,
    output logic                 alu_mode,
    input  logic [LENGTH-1:0]    alu_out,
    input  logic                 alu_carry,
    input  logic                 alu_zero,
    input  logic                 alu_sign,
    input  logic                 alu_overflow,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [LENGTH-1:0]    rsp_out,
    output logic [3:0]           rsp_flags,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;

    logic [IDW-1:0]      rr_ptr_r;
    logic [IDW-1:0]      rr_ptr_nxt_s;
    logic [IDW-1:0]      grant_idx_s;
    logic                grant_found_s;
    logic                grant_take_s;
    logic [NREQ-1:0]     grant_vec_s;
    logic [NREQ-1:0]     req_ready_s;

    logic [LENGTH-1:0]   sel_op1_s;
    logic [LENGTH-1:0]   sel_op2_s;
    logic [2:0]          sel_opc_s;
    logic                sel_mode_s;

    logic [LENGTH-1:0]   op1_r;
    logic [LENGTH-1:0]   op2_r;
    logic [2:0]          opc_r;
    logic                mode_r;
    logic [IDW-1:0]      cur_id_r;

    logic [LENGTH-1:0]   rsp_out_r;
    logic [3:0]          rsp_flags_r;
    logic [IDW-1:0]      rsp_id_r;
    logic                rsp_valid_r;
    logic                busy_r;

    // Round-robin search: the lowest valid index at or above rr_ptr wins,
    // otherwise the lowest valid index below it (wrap-around).
    always_comb begin
        logic take_hi;
        logic take_lo;
        grant_found_s = 1'b0;
        grant_idx_s   = {IDW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            take_hi       = !grant_found_s && req_valid[k] && (IDW'(k) >= rr_ptr_r);
            grant_idx_s   = take_hi ? IDW'(k) : grant_idx_s;
            grant_found_s = grant_found_s | take_hi;
        end
        for (int k = 0; k < NREQ; k++) begin
            take_lo       = !grant_found_s && req_valid[k] && (IDW'(k) < rr_ptr_r);
            grant_idx_s   = take_lo ? IDW'(k) : grant_idx_s;
            grant_found_s = grant_found_s | take_lo;
        end
    end

    // One-hot grant vector and operand selection for the winning requester.
    always_comb begin
        grant_vec_s = {NREQ{1'b0}};
        sel_op1_s   = {LENGTH{1'b0}};
        sel_op2_s   = {LENGTH{1'b0}};
        sel_opc_s   = 3'b000;
        sel_mode_s  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            grant_vec_s[k] = grant_found_s && (grant_idx_s == IDW'(k));
            sel_op1_s      = grant_vec_s[k] ? req_op1[k*LENGTH +: LENGTH] : sel_op1_s;
            sel_op2_s      = grant_vec_s[k] ? req_op2[k*LENGTH +: LENGTH] : sel_op2_s;
            sel_opc_s      = grant_vec_s[k] ? req_operation[k*3 +: 3]     : sel_opc_s;
            sel_mode_s     = grant_vec_s[k] ? req_mode[k]                 : sel_mode_s;
        end
    end

    // Pointer advances to the slot just after the winner, wrapping at NREQ-1.
    always_comb begin
        if (grant_idx_s == IDW'(NREQ - 1)) begin
            rr_ptr_nxt_s = {IDW{1'b0}};
        end else begin
            rr_ptr_nxt_s = grant_idx_s + IDW'(1'b1);
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_found_s) begin
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: begin
                state_nxt_s = RESP;
            end
            RESP: begin
                // rsp_valid is high throughout RESP, so rsp_ready alone completes it.
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output decode: accept only from IDLE and never while reset is applied.
    always_comb begin
        grant_take_s = 1'b0;
        req_ready_s  = {NREQ{1'b0}};
        if (rst_n && (state_r == IDLE)) begin
            grant_take_s = grant_found_s;
            req_ready_s  = grant_vec_s;
        end else begin
            grant_take_s = 1'b0;
            req_ready_s  = {NREQ{1'b0}};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Round-robin pointer and operand register; both change only on a grant,
    // so the ALU inputs stay frozen outside the grant edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= {IDW{1'b0}};
            op1_r    <= {LENGTH{1'b0}};
            op2_r    <= {LENGTH{1'b0}};
            opc_r    <= 3'b000;
            mode_r   <= 1'b0;
            cur_id_r <= {IDW{1'b0}};
        end else if (grant_take_s) begin
            rr_ptr_r <= rr_ptr_nxt_s;
            op1_r    <= sel_op1_s;
            op2_r    <= sel_op2_s;
            opc_r    <= sel_opc_s;
            mode_r   <= sel_mode_s;
            cur_id_r <= grant_idx_s;
        end
    end

    // Response register: captures the ALU result at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_out_r   <= {LENGTH{1'b0}};
            rsp_flags_r <= 4'b0000;
            rsp_id_r    <= {IDW{1'b0}};
        end else if (state_r == EXEC) begin
            rsp_out_r   <= alu_out;
            rsp_flags_r <= {alu_carry, alu_zero, alu_sign, alu_overflow};
            rsp_id_r    <= cur_id_r;
        end
    end

    // Registered status flags, tracking the state that is about to be entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            rsp_valid_r <= (state_nxt_s == RESP);
            busy_r      <= (state_nxt_s != IDLE);
        end
    end

    assign req_ready     = req_ready_s;
    assign alu_op1       = op1_r;
    assign alu_op2       = op2_r;
    assign alu_operation = opc_r;
    assign alu_mode      = mode_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_id        = rsp_id_r;
    assign rsp_out       = rsp_out_r;
    assign rsp_flags     = rsp_flags_r;
    assign busy          = busy_r;

    alu_share_ctrl_chk #(
        .NREQ   (NREQ),
        .LENGTH (LENGTH),
        .IDW    (IDW)
    ) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_ready (req_ready_s),
        .rsp_valid (rsp_valid_r),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id_r),
        .rsp_out   (rsp_out_r),
        .rsp_flags (rsp_flags_r),
        .busy      (busy_r)
    );

endmodule
